// File: rtl/cv32e40p_wb_stage.sv
// ----------------------------------------------------------------------------
// cv32e40p_wb_stage
//
// Write-back stage sitting directly downstream of the execute stage. Completed
// LSU / long-latency results are captured into a small in-order result buffer
// and drained into the shared register-file write port under a grant
// handshake. Pending results are forwarded to the ID stage, and retire /
// contention counters are provided for the performance unit.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid_i, ex_we_i,        execute-stage write beat (valid, write enable,
//   ex_err_i, ex_waddr_i,       LSU error, destination register, data)
//   ex_wdata_i
//   wb_ready_o                  buffer has room for another instruction
//   rf_we_o, rf_waddr_o,        register-file write request from buffer head
//   rf_wdata_o
//   rf_gnt_i                    register-file port accepted the write
//   fw_raddr_a_i, fw_raddr_b_i  ID operand source registers
//   fw_hit_a_o, fw_hit_b_o      a pending entry matches the operand
//   fw_data_a_o, fw_data_b_o    forwarded data (youngest match)
//   retire_cnt_o                committed register writes (wrapping)
//   contention_cnt_o            denied write-request cycles (saturating)
// ----------------------------------------------------------------------------
module cv32e40p_wb_stage #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic              ex_we_i,
  input  logic              ex_err_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              wb_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic              rf_gnt_i,
  input  logic [ADDR_W-1:0] fw_raddr_a_i,
  input  logic [ADDR_W-1:0] fw_raddr_b_i,
  output logic              fw_hit_a_o,
  output logic              fw_hit_b_o,
  output logic [DATA_W-1:0] fw_data_a_o,
  output logic [DATA_W-1:0] fw_data_b_o,
  output logic [31:0]       retire_cnt_o,
  output logic [15:0]       contention_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic accept;
  logic push;
  logic pop;

  // Ready depends only on the registered occupancy, so there is no
  // combinational path from the grant or the incoming valid.
  assign wb_ready_o = (count < CNT_W'(DEPTH));
  assign accept     = ex_valid_i & wb_ready_o;
  // x0 writes and error-suppressed writes are consumed without an entry.
  assign push       = accept & ex_we_i & ~ex_err_i & (ex_waddr_i != '0);

  assign rf_we_o    = (count != '0);
  assign rf_waddr_o = rf_we_o ? buf_addr[rd_ptr] : '0;
  assign rf_wdata_o = rf_we_o ? buf_data[rd_ptr] : '0;
  assign pop        = rf_we_o & rf_gnt_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      retire_cnt_o     <= '0;
      contention_cnt_o <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      if (push) begin
        buf_addr[wr_ptr] <= ex_waddr_i;
        buf_data[wr_ptr] <= ex_wdata_i;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_W'(1);
        retire_cnt_o <= retire_cnt_o + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (rf_we_o && !rf_gnt_i && contention_cnt_o != 16'hFFFF) begin
        contention_cnt_o <= contention_cnt_o + 16'd1;
      end
    end
  end

  // Walk the live entries from oldest to youngest so a later match
  // overrides an earlier one, giving youngest-wins priority.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    fw_hit_a_o  = 1'b0;
    fw_hit_b_o  = 1'b0;
    fw_data_a_o = '0;
    fw_data_b_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (buf_addr[idx] == fw_raddr_a_i && fw_raddr_a_i != '0) begin
          fw_hit_a_o  = 1'b1;
          fw_data_a_o = buf_data[idx];
        end
        if (buf_addr[idx] == fw_raddr_b_i && fw_raddr_b_i != '0) begin
          fw_hit_b_o  = 1'b1;
          fw_data_b_o = buf_data[idx];
        end
      end
    end
  end

endmodule
